// File: rtl/pipe_alu.sv
// pipe_alu: valid/ready ALU with a registered result and {N,Z,C,V} flags.
// Single-cycle operations complete on the accepting edge. The iterative
// shift-add multiply (opcode 1010) exists only when PIPE_ALU_MUL_EN is
// defined. Without it, 1010 decodes as an undefined opcode and the block
// never leaves RUN.
module pipe_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             busy
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLTU = 4'b0101;
   localparam logic [3:0] OP_SLL  = 4'b0110;
   localparam logic [3:0] OP_SRL  = 4'b0111;
   localparam logic [3:0] OP_SRA  = 4'b1000;
   localparam logic [3:0] OP_SLT  = 4'b1001;

   logic                    accept;
   logic                    run;
   logic                    mul_start;
   logic                    mul_done;
   logic [WIDTH-1:0]        mul_res;
   logic [WIDTH-1:0]        alu_res;
   logic                    alu_c;
   logic                    alu_v;
   logic [WIDTH:0]          add_full;
   logic [WIDTH:0]          sub_full;
   logic signed [WIDTH-1:0] a_s;
   logic signed [WIDTH-1:0] b_s;
   logic [SHW-1:0]          shamt;

   // The extra top bit of add_full is the carry; in sub_full it is the borrow (a < b).
   assign add_full = {1'b0, a} + {1'b0, b};
   assign sub_full = {1'b0, a} - {1'b0, b};
   assign a_s      = a;
   assign b_s      = b;
   assign shamt    = b[SHW-1:0];

   // A new bundle is taken only in RUN, and only when the output slot is empty or draining.
   assign in_ready = run && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // Single-cycle result and carry/overflow; undefined opcodes fall through to zero.
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (opcode)
         OP_ADD: begin
            alu_res = add_full[WIDTH-1:0];
            alu_c   = add_full[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = sub_full[WIDTH-1:0];
            alu_c   = sub_full[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SLL:  alu_res = a << shamt;
         OP_SRL:  alu_res = a >> shamt;
         OP_SRA:  alu_res = a_s >>> shamt;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
         default: ;
      endcase
   end

`ifdef PIPE_ALU_MUL_EN
   localparam logic [3:0]   OP_MUL   = 4'b1010;
   localparam logic [SHW:0] CNT_LOAD = (SHW+1)'(WIDTH);
   localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

   typedef enum logic {RUN, MUL} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [SHW:0]     cnt;
   logic [SHW:0]     cnt_nxt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;

   assign run       = (state == RUN);
   assign busy      = (state == MUL);
   assign mul_start = accept && (opcode == OP_MUL);
   assign mul_done  = busy && (cnt == CNT_ONE);
   // Accumulator after the current step; on the last step this is the product.
   assign mul_res   = acc + (mplier[0] ? mcand : '0);

   // State and step-counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // RUN launches a multiply; MUL runs WIDTH steps and returns to RUN on the last.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         RUN: begin
            if (mul_start) begin
               state_nxt = MUL;
               cnt_nxt   = CNT_LOAD;
            end
         end
         MUL: begin
            cnt_nxt = cnt - CNT_ONE;
            if (cnt == CNT_ONE) state_nxt = RUN;
         end
      endcase
   end

   // Shift-add datapath: multiplicand moves left, multiplier moves right, one bit per cycle.
   always_ff @(posedge clk) begin
      if (mul_start) begin
         acc    <= '0;
         mcand  <= a;
         mplier <= b;
      end else if (busy) begin
         acc    <= mul_res;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end
`else
   assign run       = 1'b1;
   assign busy      = 1'b0;
   assign mul_start = 1'b0;
   assign mul_done  = 1'b0;
   assign mul_res   = '0;
`endif

   // Output slot: load on completion, clear when a multiply starts, drain on out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
      end else if (mul_done) begin
         out_valid <= 1'b1;
         result    <= mul_res;
         flags     <= {mul_res[WIDTH-1], (mul_res == '0), 2'b00};
      end else if (mul_start) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         result    <= alu_res;
         flags     <= {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pipe_alu.sv
// Testbench for pipe_alu (WIDTH=8): vector table plus random traffic through a
// scoreboard queue, with hand sequences for stall, multiply timing and reset.
module tb_pipe_alu;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [3:0] opcode;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic [3:0] flags;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int delivered = 0;
   logic rdy_random = 1'b0;
   logic [11:0] sbq[$];

   pipe_alu #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flags(flags), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] op;
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] res;
      logic [3:0] flg;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour written from the operation definitions: {result, N, Z, C, V}.
   function automatic logic [11:0] model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
      int sx, sy, t;
      logic signed [7:0] xs;
      logic [7:0] r;
      logic c, v;
      sx = $signed(x);
      sy = $signed(y);
      xs = x;
      r = 8'h00;
      c = 1'b0;
      v = 1'b0;
      case (op)
         4'd0: begin t = int'(x) + int'(y); r = t[7:0]; c = (t > 255); t = sx + sy; v = (t > 127) || (t < -128); end
         4'd1: begin t = int'(x) - int'(y); r = t[7:0]; c = (x < y); t = sx - sy; v = (t > 127) || (t < -128); end
         4'd2: r = x & y;
         4'd3: r = x | y;
         4'd4: r = x ^ y;
         4'd5: r = (x < y) ? 8'd1 : 8'd0;
         4'd6: r = x << y[2:0];
         4'd7: r = x >> y[2:0];
         4'd8: r = xs >>> y[2:0];
         4'd9: r = (sx < sy) ? 8'd1 : 8'd0;
`ifdef PIPE_ALU_MUL_EN
         4'd10: begin t = int'(x) * int'(y); r = t[7:0]; end
`endif
         default: r = 8'h00;
      endcase
      return {r, r[7], (r == 8'h00), c, v};
   endfunction

   // Scoreboard: every transfer (out_valid && out_ready) pops and compares the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0h with no pending expectation", result);
         end else begin
            logic [11:0] e;
            e = sbq.pop_front();
            chk("sb_result", result, e[11:4]);
            chk("sb_flags", flags, e[3:0]);
            delivered++;
         end
      end
   end

   // Present one bundle, hold it until accepted, record the expectation at the accepting edge.
   task automatic drive(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y, output int waited);
      logic r;
      in_valid = 1'b1;
      opcode = op;
      a = x;
      b = y;
      waited = 0;
      forever begin
         @(negedge clk);
         r = in_ready;
         @(posedge clk);
         if (r) begin
            sbq.push_back(model(op, x, y));
            break;
         end
         waited++;
         if (waited > 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: op %0h not accepted after %0d cycles", op, waited);
            break;
         end
         #1;
         if (rdy_random) out_ready = 1'($urandom_range(0, 1));
      end
      #1;
      in_valid = 1'b0;
      if (rdy_random) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic drain();
      int n;
      out_ready = 1'b1;
      n = 0;
      while (sbq.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_empty", sbq.size(), 0);
   endtask

   initial begin
      vec_t vt[16];
      int w;
      int base;

      vt[0]  = '{4'h0, 8'hFF, 8'h01, 8'h00, 4'b0110};
      vt[1]  = '{4'h1, 8'h80, 8'h01, 8'h7F, 4'b0001};
      vt[2]  = '{4'h9, 8'hFE, 8'h01, 8'h01, 4'b0000};
      vt[3]  = '{4'h5, 8'hFE, 8'h01, 8'h00, 4'b0100};
      vt[4]  = '{4'h8, 8'h90, 8'h0A, 8'hE4, 4'b1000};
      vt[5]  = '{4'h6, 8'h01, 8'h07, 8'h80, 4'b1000};
      vt[6]  = '{4'h2, 8'hF0, 8'h3C, 8'h30, 4'b0000};
      vt[7]  = '{4'h3, 8'hF0, 8'h0C, 8'hFC, 4'b1000};
      vt[8]  = '{4'h4, 8'hAA, 8'hAA, 8'h00, 4'b0100};
      vt[9]  = '{4'h7, 8'h80, 8'h0F, 8'h01, 4'b0000};
      vt[10] = '{4'h0, 8'h7F, 8'h01, 8'h80, 4'b1001};
      vt[11] = '{4'h1, 8'h01, 8'h02, 8'hFF, 4'b1010};
      vt[12] = '{4'hF, 8'h12, 8'h34, 8'h00, 4'b0100};
      vt[13] = '{4'h1, 8'h05, 8'h05, 8'h00, 4'b0100};
      vt[14] = '{4'h6, 8'h41, 8'h09, 8'h82, 4'b1000};
      vt[15] = '{4'h0, 8'h80, 8'h80, 8'h00, 4'b0111};

      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      opcode = 4'h0;
      a = 8'h00;
      b = 8'h00;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", flags, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Vector table, back to back with out_ready held high.
      out_ready = 1'b1;
      foreach (vt[i]) begin
         chk("table_model", model(vt[i].op, vt[i].x, vt[i].y), {vt[i].res, vt[i].flg});
         sbq.push_back({vt[i].res, vt[i].flg});
         drive(vt[i].op, vt[i].x, vt[i].y, w);
         void'(sbq.pop_back());
         chk("table_no_stall", w, 0);
      end
      drain();

      // Four ADDs; consumer stalls for three cycles after the first result.
      base = delivered;
      out_ready = 1'b1;
      in_valid = 1'b1;
      opcode = 4'h0;
      a = 8'd1;
      b = 8'd1;
      @(negedge clk);
      chk("stall_ready_before", in_ready, 1);
      @(posedge clk);
      sbq.push_back(model(4'h0, 8'd1, 8'd1));
      #1;
      a = 8'd2;
      b = 8'd2;
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_out_valid", out_valid, 1);
         chk("stall_hold_result", result, 8'h02);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      for (int k = 2; k <= 4; k++) begin
         a = 8'(k);
         b = 8'(k);
         @(posedge clk);
         sbq.push_back(model(4'h0, 8'(k), 8'(k)));
         #1;
      end
      in_valid = 1'b0;
      drain();
      chk("stall_delivered", delivered - base, 4);

`ifdef PIPE_ALU_MUL_EN
      // Multiply 13*11: eight busy cycles, result on the ninth.
      out_ready = 1'b1;
      in_valid = 1'b1;
      opcode = 4'hA;
      a = 8'd13;
      b = 8'd11;
      @(posedge clk);
      sbq.push_back({8'h8F, 4'b1000});
      #1;
      in_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("mul_busy", busy, 1);
         chk("mul_in_ready", in_ready, 0);
         chk("mul_no_out", out_valid, 0);
         @(posedge clk);
      end
      @(negedge clk);
      chk("mul_out_valid", out_valid, 1);
      chk("mul_busy_done", busy, 0);
      chk("mul_result", result, 8'h8F);
      @(posedge clk);
      #1;

      // Reset in cycle 4 of a multiply aborts it.
      in_valid = 1'b1;
      opcode = 4'hA;
      a = 8'd7;
      b = 8'd9;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_busy_before", busy, 1);
`else
      // Hold a nonzero result in the output slot, then reset.
      out_ready = 1'b0;
      in_valid = 1'b1;
      opcode = 4'h0;
      a = 8'h10;
      b = 8'h20;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("hold_before_reset", result, 8'h30);
      chk("mul_off_busy", busy, 0);
`endif
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_result", result, 0);
      chk("abort_flags", flags, 0);
      chk("abort_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_valid = 1'b1;
      opcode = 4'h0;
      a = 8'd2;
      b = 8'd3;
      @(posedge clk);
      sbq.push_back(model(4'h0, 8'd2, 8'd3));
      #1;
      in_valid = 1'b0;
      chk("post_reset_lat1", out_valid, 1);
      chk("post_reset_sum", result, 8'd5);
      drain();

      // Random operations with a randomly stalling consumer.
      rdy_random = 1'b1;
      for (int k = 0; k < 60; k++) begin
         drive(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), w);
      end
      rdy_random = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/pipe_alu.md
PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; SHALL be a power of two, 4..64.
REQ-002 Local parameter SHW = $clog2(WIDTH), shift-amount width, SHALL derive from WIDTH.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand bundle valid.
REQ-006 in_ready  output  1  block accepts a bundle this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 opcode  input  4  operation select.
REQ-010 out_valid  output  1  result/flags valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 result  output  WIDTH  registered result.
REQ-013 flags  output  4  registered {N,Z,C,V}.
REQ-014 busy  output  1  multi-cycle operation in progress.

Function
REQ-015 Accept SHALL occur only on a rising edge where in_valid && in_ready; a, b, opcode are sampled at that edge.
REQ-016 in_ready SHALL = (state==RUN) && (!out_valid || out_ready), combinational.
REQ-017 Opcodes SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLTU (unsigned A<B -> 1), 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLT (signed), 1010 MUL; 1011-1111 undefined.
REQ-018 Shifts SHALL use b[SHW-1:0] only; SRA SHALL replicate a[WIDTH-1].
REQ-019 SLT/SLTU SHALL produce zero-extended 0 or 1 in result.
REQ-020 Undefined opcodes SHALL produce result 0, flags 4'b0100, latency 1.
REQ-021 Single-cycle ops SHALL set out_valid on the edge of acceptance (out_valid visible 1 cycle after accept); sustained throughput 1 op/cycle when out_ready=1.
REQ-022 Z SHALL = (result==0); N SHALL = result[WIDTH-1]; for every op.
REQ-023 C SHALL = carry out of ADD, = borrow (A<B unsigned) for SUB, 0 otherwise.
REQ-024 V SHALL = signed overflow for ADD/SUB, 0 otherwise; all arithmetic wraps modulo 2^WIDTH.
REQ-025 While out_valid && !out_ready, result and flags SHALL hold stable and no bundle is accepted.
REQ-026 out_valid SHALL clear on out_ready unless a new bundle is accepted that same edge (simultaneous drain+accept replaces the result, out_valid stays 1).
REQ-027 State machine: RUN (single-cycle ops), MUL (iterative multiply); busy SHALL = (state==MUL).
REQ-028 MUL accept in RUN SHALL go to MUL, load a shift-add counter with WIDTH, and clear out_valid (prior result drained by the same edge per REQ-016).
REQ-029 In MUL, one partial-product step SHALL execute per cycle; after WIDTH steps result = low WIDTH bits of a*b (unsigned), flags per REQ-022, C=V=0, out_valid=1, state returns to RUN.
REQ-030 MUL latency SHALL be WIDTH+1 cycles from accept to out_valid; in_ready SHALL be 0 throughout MUL.

Reset
REQ-031 rst_n low SHALL asynchronously force state=RUN, out_valid=0, result=0, flags=0, counter=0, busy=0.
REQ-032 Reset during MUL SHALL abort the operation with no output produced; in_ready SHALL be 1 while in reset and after release.

Configuration
REQ-033 Macro PIPE_ALU_MUL_EN defined: MUL opcode, MUL state and counter SHALL be present per REQ-027..030.
REQ-034 PIPE_ALU_MUL_EN undefined: 1010 SHALL behave as undefined (REQ-020), state fixed at RUN, busy tied 0, no multiplier logic synthesised.

Verification
REQ-035 WIDTH=8, ADD a=8'hFF b=8'h01, out_ready=1 -> next cycle out_valid=1, result=8'h00, flags N0 Z1 C1 V0.
REQ-036 WIDTH=8, SUB a=8'h80 b=8'h01 -> result=8'h7F, flags N0 Z0 C0 V1; SLT a=8'hFE b=8'h01 -> 1, SLTU -> 0.
REQ-037 WIDTH=8, SRA a=8'h90 b=8'h0A (shamt 2) -> result=8'hE4; SLL a=8'h01 b=8'h07 -> 8'h80, N=1.
REQ-038 MUL_EN, WIDTH=8, MUL a=13 b=11 -> busy=1 and in_ready=0 for 8 cycles, out_valid at cycle 9, result=8'h8F.
REQ-039 Back-to-back 4 ADDs with out_ready low for 3 cycles after the first -> result held, in_ready=0 while stalled, all 4 results delivered in order, none lost or duplicated.
REQ-040 MUL_EN, rst_n pulsed low at cycle 4 of a MUL -> out_valid=0, busy=0, result=0 immediately; next ADD 2+3 after release -> 5 at latency 1.
